// File: rtl/pdm_tx.sv
// PCM-to-PDM transmitter: one-entry sample queue feeding a first-order error-feedback
// sigma-delta modulator; one PDM bit per CLK_DIV clocks, upstream stalls on s_ready.
module pdm_tx #(
  parameter int CLK_DIV      = 40,
  parameter int SAMPLE_WIDTH = 16,
  parameter int OSR          = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [SAMPLE_WIDTH-1:0] s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic                           pdm_clk,
  output logic                           pdm_data,
  output logic                           sample_load,
  output logic                           underrun
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_WIDTH-1:0] acc_q, acc_d;
  logic [SAMPLE_WIDTH-1:0] cur_q, cur_d;
  logic [SAMPLE_WIDTH-1:0] next_q, next_d;
  logic                    next_full_q, next_full_d;
  logic                    pdm_clk_q, pdm_clk_d;
  logic                    pdm_data_q, pdm_data_d;
  logic                    s_ready_q, s_ready_d;
  logic                    sample_load_q, sample_load_d;
  logic                    underrun_q, underrun_d;

  logic                    bit_tick;
  logic                    osr_end;
  logic                    accept;
  logic [SAMPLE_WIDTH-1:0] u;
  logic [SAMPLE_WIDTH:0]   sum;

  assign bit_tick = (div_cnt_q == DIV_LAST);
  assign osr_end  = bit_tick && (bit_cnt_q == BIT_LAST);
  assign accept   = s_valid && s_ready_q;

  // Flipping the sign bit turns two's complement into offset binary.
  assign u   = {~cur_q[SAMPLE_WIDTH-1], cur_q[SAMPLE_WIDTH-2:0]};
  assign sum = {1'b0, acc_q} + {1'b0, u};

  always_comb begin
    div_cnt_d = bit_tick ? '0 : div_cnt_q + DIV_W'(1);
    pdm_clk_d = (div_cnt_d >= DIV_HALF);
  end

  always_comb begin
    acc_d      = acc_q;
    pdm_data_d = pdm_data_q;
    bit_cnt_d  = bit_cnt_q;
    if (bit_tick) begin
      acc_d      = sum[SAMPLE_WIDTH-1:0];
      pdm_data_d = sum[SAMPLE_WIDTH];
      bit_cnt_d  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    next_d        = next_q;
    next_full_d   = next_full_q;
    sample_load_d = 1'b0;
    underrun_d    = 1'b0;
    if (osr_end) begin
      if (next_full_q) begin
        cur_d         = next_q;
        next_full_d   = 1'b0;
        sample_load_d = 1'b1;
        state_d       = RUN;
      end else begin
        case (state_q)
          RUN:     underrun_d = 1'b1;
          default: underrun_d = 1'b0;
        endcase
      end
    end
    // A boundary-cycle handshake lands after the boundary decision, so it waits one block.
    if (accept) begin
      next_d      = s_data;
      next_full_d = 1'b1;
    end
    s_ready_d = ~next_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      acc_q         <= '0;
      cur_q         <= '0;
      next_q        <= '0;
      next_full_q   <= 1'b0;
      pdm_clk_q     <= 1'b0;
      pdm_data_q    <= 1'b0;
      s_ready_q     <= 1'b0;
      sample_load_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      acc_q         <= acc_d;
      cur_q         <= cur_d;
      next_q        <= next_d;
      next_full_q   <= next_full_d;
      pdm_clk_q     <= pdm_clk_d;
      pdm_data_q    <= pdm_data_d;
      s_ready_q     <= s_ready_d;
      sample_load_q <= sample_load_d;
      underrun_q    <= underrun_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign pdm_clk     = pdm_clk_q;
  assign pdm_data    = pdm_data_q;
  assign sample_load = sample_load_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_pdm_tx.sv
// Bench for pdm_tx: cumulative-sum sigma-delta model checked every cycle, plus directed
// scenarios with hand-computed bit patterns, densities and pulse timing.
module tb_pdm_tx;
  localparam int CLK_DIV = 40;
  localparam int OSR     = 64;
  localparam int SW      = 16;
  localparam int BLK     = OSR * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic signed [SW-1:0] s_data = '0;
  logic s_ready, pdm_clk, pdm_data, sample_load, underrun;

  int checks = 0;
  int failures = 0;

  pdm_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_WIDTH(SW), .OSR(OSR)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .pdm_clk(pdm_clk), .pdm_data(pdm_data), .sample_load(sample_load), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: output bit n is the carry of floor(sum of offset-binary samples / 2^SW).
  logic signed [SW-1:0] m_cur, m_next;
  bit     m_on = 0, m_full, m_run, m_ready, m_data, m_load, m_und, m_hs;
  longint m_cyc, m_bits, m_total, m_hi;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1; m_cyc = 0; m_bits = 0; m_total = 0; m_hi = 0;
      m_cur = 0; m_next = 0; m_full = 0; m_run = 0; m_ready = 0;
      m_data = 0; m_load = 0; m_und = 0;
    end else if (m_on) begin
      m_hs = s_valid && m_ready;
      m_load = 0;
      m_und = 0;
      if (m_cyc % CLK_DIV == CLK_DIV - 1) begin
        m_total += longint'(m_cur) + 32768;
        m_data = ((m_total >> SW) != m_hi);
        m_hi = m_total >> SW;
        if (m_bits % OSR == OSR - 1) begin
          if (m_full) begin
            m_cur = m_next; m_full = 0; m_load = 1; m_run = 1;
          end else if (m_run) begin
            m_und = 1;
          end
        end
        m_bits++;
      end
      if (m_hs) begin
        m_next = s_data;
        m_full = 1;
      end
      m_ready = !m_full;
      m_cyc++;
    end
  end

  bit   st_ok = 0;
  logic st_clk, st_data;
  always @(negedge clk) begin
    if (m_on) begin
      chk("pdm_clk", pdm_clk, logic'((m_cyc % CLK_DIV) >= CLK_DIV / 2));
      chk("pdm_data", pdm_data, m_data);
      chk("s_ready", s_ready, m_ready);
      chk("sample_load", sample_load, m_load);
      chk("underrun", underrun, m_und);
      if (st_ok && (pdm_data !== st_data)) chk("data_only_on_fall", {st_clk, pdm_clk}, 2'b10);
      st_clk = pdm_clk;
      st_data = pdm_data;
      st_ok = 1;
    end
  end

  // Logger: PDM bits captured at each falling pdm_clk, plus pulse bookkeeping.
  longint cyc = 0;
  bit     bits[$];
  longint fall_cyc[$];
  longint load_cyc[$];
  int     load_idx = 0, und_idx = 0, n_load = 0, n_und = 0;
  logic   lg_prev;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pdm_clk === 1'b0 && lg_prev === 1'b1) begin
      bits.push_back(pdm_data);
      fall_cyc.push_back(cyc);
    end
    if (sample_load === 1'b1) begin
      load_idx = bits.size();
      n_load++;
      load_cyc.push_back(cyc);
    end
    if (underrun === 1'b1) begin
      und_idx = bits.size();
      n_und++;
    end
    lg_prev = pdm_clk;
  end

  function automatic int ones(input int s, input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(bits[s + i]);
    return c;
  endfunction

  function automatic logic [3:0] first4(input int s);
    return {bits[s], bits[s + 1], bits[s + 2], bits[s + 3]};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_load(output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * BLK + 100; i++) begin
      if (sample_load === 1'b1) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic wait_und(output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * BLK + 100; i++) begin
      if (underrun === 1'b1) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic wait_bits(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 4 * BLK; i++) begin
      if (bits.size() >= n) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic send(input logic signed [SW-1:0] v, input bit hold, output bit ok);
    bit r;
    ok = 0;
    s_data = v;
    s_valid = 1'b1;
    for (int i = 0; i < 3 * BLK; i++) begin
      r = (s_ready === 1'b1);
      tick();
      if (r) begin ok = 1; break; end
    end
    if (!hold) s_valid = 1'b0;
  endtask

  initial begin
    bit     ok;
    int     idx, hi, first, u0, nl, n;
    longint c0;

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_pdm_clk", pdm_clk, 0);
    chk("rst_pdm_data", pdm_data, 0);
    chk("rst_s_ready", s_ready, 0);
    rst = 1'b0;
    c0 = cyc;
    idx = bits.size();

    // Idle: 20 low / 20 high clocks, midscale 0101 pattern, no pulses
    hi = 0;
    first = -1;
    for (int i = 0; i < CLK_DIV; i++) begin
      if (pdm_clk === 1'b1) begin
        hi++;
        if (first < 0) first = i;
      end
      tick();
    end
    chk("clk_high_cycles", hi, 20);
    chk("clk_first_high", first, 20);
    wait_bits(idx + 3 * OSR, ok);
    chk("idle_bits_seen", ok, 1);
    if (ok) begin
      chk("idle_first_bits", first4(idx), 4'b0101);
      chk("idle_ones", ones(idx, OSR), 32);
      chk("idle_first_fall", fall_cyc[idx] - c0, CLK_DIV);
      chk("idle_period", fall_cyc[idx + 1] - fall_cyc[idx], CLK_DIV);
    end
    chk("idle_pulses", n_load + n_und, 0);

    // First load of 0x4000 with acc=0: 0,1,1,1 repeating
    send(16'sh4000, 0, ok);
    chk("send_4000", ok, 1);
    wait_load(ok);
    chk("load_4000", ok, 1);
    idx = load_idx;
    wait_bits(idx + OSR, ok);
    if (ok) begin
      chk("q3_first_bits", first4(idx), 4'b0111);
      chk("q3_ones", ones(idx, OSR), 48);
    end

    // Underrun; then a handshake exactly on the next boundary tick
    wait_und(ok);
    chk("und_after_4000", ok, 1);
    idx = und_idx;
    repeat (BLK - 1) tick();
    s_data = 16'sh8000;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("edge_hs_underrun", underrun, 1);
    chk("edge_hs_no_load", sample_load, 0);
    wait_bits(idx + OSR, ok);
    if (ok) chk("und_block_ones", ones(idx, OSR), 48);
    wait_load(ok);
    chk("load_neg_fs", ok, 1);
    idx = load_idx;
    wait_bits(idx + OSR, ok);
    if (ok) chk("neg_fs_ones", ones(idx, OSR), 0);

    send(16'sh7FFF, 0, ok);
    chk("send_pos_fs", ok, 1);
    wait_load(ok);
    idx = load_idx;
    wait_bits(idx + OSR, ok);
    if (ok) chk("pos_fs_ones_ge63", ones(idx, OSR) >= OSR - 1, 1);

    // Backpressure with s_valid held across three samples
    u0 = n_und;
    send(16'sh0000, 1, ok);
    chk("bp_send_a", ok, 1);
    send(16'sh2000, 1, ok);
    chk("bp_send_b", ok, 1);
    send(16'shE000, 0, ok);
    chk("bp_send_c", ok, 1);
    wait_load(ok);
    chk("bp_load_c", ok, 1);
    n = load_cyc.size();
    chk("bp_interval_ab", load_cyc[n - 2] - load_cyc[n - 3], BLK);
    chk("bp_interval_bc", load_cyc[n - 1] - load_cyc[n - 2], BLK);
    chk("bp_no_underrun", n_und - u0, 0);

    // Reset mid high-phase with a queued sample
    send(16'sh1234, 0, ok);
    chk("send_queued", ok, 1);
    for (int i = 0; i < 2 * CLK_DIV; i++) begin
      if (pdm_clk === 1'b1) break;
      tick();
    end
    rst = 1'b1;
    tick();
    c0 = cyc;
    chk("mid_rst_pdm_clk", pdm_clk, 0);
    chk("mid_rst_pdm_data", pdm_data, 0);
    rst = 1'b0;
    tick();
    chk("mid_rst_s_ready", s_ready, 1);
    idx = bits.size();
    nl = n_load;
    wait_bits(idx + OSR, ok);
    chk("mid_rst_bits_seen", ok, 1);
    if (ok) begin
      chk("mid_rst_first_fall", fall_cyc[idx] - c0, CLK_DIV);
      chk("mid_rst_first_bits", first4(idx), 4'b0101);
      chk("mid_rst_ones", ones(idx, OSR), 32);
    end
    chk("mid_rst_queue_lost", n_load - nl, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
